// File: rtl/mem_module_if.sv
// Write/read port bundle for mem_module. The master side drives the requests,
// and the slave side returns the registered read result.
interface mem_module_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 2
);
    logic                  wr_en;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/mem_module.sv
// Simple dual-port RAM with registered reads and per-word valid bits.
// Define MEM_MOD_BYPASS_EN for write-first collisions; the default build is read-first.
module mem_module #(
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_ADDR   = 4,
    localparam int ADDR_SIZE  = $clog2(MAX_ADDR)
) (
    input  logic       clk,
    input  logic       rst,
    mem_module_if.slave bus
);
    localparam logic [ADDR_SIZE:0] MAX_A = (ADDR_SIZE+1)'(MAX_ADDR);

    logic [DATA_WIDTH-1:0] mem_q [MAX_ADDR];
    logic [MAX_ADDR-1:0]   valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_hit, rd_in, collide;

    // The extra MSB lets the range compare work when MAX_ADDR is a power of two.
    assign wr_hit  = bus.wr_en && ({1'b0, bus.wr_addr} < MAX_A);
    assign rd_in   = {1'b0, bus.rd_addr} < MAX_A;
    assign collide = wr_hit && rd_in && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        valid_d = valid_q;
        if (wr_hit) valid_d[bus.wr_addr] = 1'b1;
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        if (bus.rd_en) begin
            if (!rd_in) begin
                rd_data_d = '0;
`ifdef MEM_MOD_BYPASS_EN
            end else if (collide) begin
                rd_data_d = bus.wr_data;
`endif
            end else if (valid_q[bus.rd_addr]) begin
                rd_data_d = mem_q[bus.rd_addr];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // The array is left uncleared at reset because the valid vector masks stale words.
    always_ff @(posedge clk) begin
        if (!rst && wr_hit) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifndef MEM_MOD_BYPASS_EN
    logic unused_collide;
    assign unused_collide = collide;
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mem_module.sv
// Randomized and directed bench for mem_module (MAX_ADDR=5) with a behavioural reference model.
module tb_mem_module;
    localparam int DW = 8;
    localparam int MAXA = 5;
    localparam int AW = 3;
`ifdef MEM_MOD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_module_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus();
    mem_module #(.DATA_WIDTH(DW), .MAX_ADDR(MAXA)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Only written words are present in the model; a missing key reads as zero.
    int unsigned store [int];
    int unsigned exp_data = 0;
    bit          exp_valid = 1'b0;

    always @(posedge clk) begin
        int wa, ra;
        int unsigned old;
        wa = int'(bus.wr_addr);
        ra = int'(bus.rd_addr);
        if (rst) begin
            store.delete();
            exp_data  = 0;
            exp_valid = 1'b0;
        end else begin
            old = store.exists(ra) ? store[ra] : 0;
            if (bus.rd_en) begin
                exp_valid = 1'b1;
                if (ra >= MAXA) exp_data = 0;
                else if (BYPASS && bus.wr_en && wa == ra) exp_data = int'(bus.wr_data);
                else exp_data = old;
            end else begin
                exp_valid = 1'b0;
            end
            if (bus.wr_en && wa < MAXA) store[wa] = int'(bus.wr_data);
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (bus.rd_valid !== exp_valid) begin
                errors++;
                $display("FAIL model_rd_valid t=%0t got %b expected %b", $time, bus.rd_valid, exp_valid);
            end
            checks++;
            if ({24'd0, bus.rd_data} !== exp_data) begin
                errors++;
                $display("FAIL model_rd_data t=%0t got %0d expected %0d", $time, bus.rd_data, exp_data);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then stop just after the edge so the outputs can be checked.
    task automatic cyc(input bit r, input bit we, input int wa, input int wd,
                       input bit re, input int ra);
        rst         = r;
        bus.wr_en   = we;
        bus.wr_addr = AW'(wa);
        bus.wr_data = DW'(wd);
        bus.rd_en   = re;
        bus.rd_addr = AW'(ra);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int fill [4];
        fill = '{128, 56, 74, 200};
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        lit("reset_rd_data", {24'd0, bus.rd_data}, 0);
        lit("reset_rd_valid", {31'd0, bus.rd_valid}, 0);

        cyc(0, 0, 0, 0, 1, 1);
        lit("unwritten_rd", {24'd0, bus.rd_data}, 0);
        lit("unwritten_vld", {31'd0, bus.rd_valid}, 1);

        for (int i = 0; i < 4; i++) cyc(0, 1, i, fill[i], 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, i);
            lit($sformatf("fill_rd%0d", i), {24'd0, bus.rd_data}, fill[i]);
            lit($sformatf("fill_vld%0d", i), {31'd0, bus.rd_valid}, 1);
        end
        cyc(0, 0, 0, 0, 0, 3);
        lit("hold_data", {24'd0, bus.rd_data}, 74);
        lit("hold_vld", {31'd0, bus.rd_valid}, 0);
        cyc(0, 0, 0, 0, 1, 3);
        lit("fill_rd3", {24'd0, bus.rd_data}, 200);

        cyc(0, 1, 6, 99, 0, 0);
        cyc(0, 0, 0, 0, 1, 6);
        lit("oor_rd", {24'd0, bus.rd_data}, 0);
        lit("oor_vld", {31'd0, bus.rd_valid}, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, i);
        lit("oor_no_clobber", {24'd0, bus.rd_data}, 200);

        cyc(0, 1, 1, 17, 1, 1);
        lit("collide_rd", {24'd0, bus.rd_data}, BYPASS ? 17 : 56);
        lit("collide_vld", {31'd0, bus.rd_valid}, 1);
        cyc(0, 0, 0, 0, 1, 1);
        lit("after_collide", {24'd0, bus.rd_data}, 17);

        cyc(1, 1, 0, 5, 1, 0);
        lit("midrst_data", {24'd0, bus.rd_data}, 0);
        lit("midrst_vld", {31'd0, bus.rd_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, i);
            lit($sformatf("postrst_rd%0d", i), {24'd0, bus.rd_data}, 0);
        end

        cyc(0, 1, 0, 10, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 1, k, 10 + k, 1, k - 1);
            lit($sformatf("b2b_rd%0d", k - 1), {24'd0, bus.rd_data}, 10 + k - 1);
        end

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 7));
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
